// File: rtl/sync_handshake_data.sv
// Single-word toggle-handshake crossing from sCLK to dCLK; only toggles are synchronised.
// Define SYNC_HANDSHAKE_DATA_OVERRUN_EN to add sCLR, sOVERRUN and sDROPCNT.
module sync_handshake_data #(
    parameter int unsigned       WIDTH    = 8,
    parameter int unsigned       STAGES   = 2,
    parameter logic              INIT     = 1'b0,
    parameter int unsigned       ACK_MODE = 0,
    parameter logic [WIDTH-1:0]  DINIT    = '0
) (
    input  logic             sCLK,
    input  logic             sRST_N,
    input  logic             dCLK,
    input  logic             sEN,
    input  logic [WIDTH-1:0] sD_IN,
    output logic             sRDY,
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
    input  logic             sCLR,
    output logic             sOVERRUN,
    output logic [7:0]       sDROPCNT,
`endif
    input  logic             dACK,
    output logic             dVALID,
    output logic [WIDTH-1:0] dD_OUT
);

    logic              r_s_tog;
    logic [WIDTH-1:0]  r_s_data;
    logic [STAGES-1:0] r_s_ack_sync;
    logic [STAGES-1:0] r_d_req_sync;
    logic              r_d_ack_tog;

    logic w_s_fire;
    logic w_d_req;
    logic w_d_ack_nxt;

    assign sRDY     = (r_s_ack_sync[STAGES-1] == r_s_tog);
    assign w_s_fire = sEN & sRDY;

    // Source side: capture word and flip request toggle
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            r_s_tog  <= INIT;
            r_s_data <= DINIT;
        end else if (w_s_fire) begin
            r_s_tog  <= ~r_s_tog;
            r_s_data <= sD_IN;
        end
    end

    // Return crossing resets to the opposite of INIT so sRDY stays low until it flushes
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            r_s_ack_sync <= {STAGES{~INIT}};
        end else begin
            r_s_ack_sync <= {r_s_ack_sync[STAGES-2:0], r_d_ack_tog};
        end
    end

    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            r_d_req_sync <= {STAGES{INIT}};
        end else begin
            r_d_req_sync <= {r_d_req_sync[STAGES-2:0], r_s_tog};
        end
    end

    assign w_d_req = r_d_req_sync[STAGES-1];
    assign dVALID  = (w_d_req != r_d_ack_tog);

    // Auto mode follows the request every edge; explicit mode waits for dACK
    assign w_d_ack_nxt = (ACK_MODE == 0) ? w_d_req
                                         : (r_d_ack_tog ^ (dVALID & dACK));

    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            r_d_ack_tog <= INIT;
        end else begin
            r_d_ack_tog <= w_d_ack_nxt;
        end
    end

    // Source register is frozen while dVALID is high, so no data synchroniser
    assign dD_OUT = r_s_data;

`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
    logic       r_s_ovr;
    logic [7:0] r_s_drop;
    logic       w_s_drop;

    assign w_s_drop = sEN & ~sRDY;

    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            r_s_ovr  <= 1'b0;
            r_s_drop <= 8'd0;
        end else if (sCLR) begin
            r_s_ovr  <= 1'b0;
            r_s_drop <= 8'd0;
        end else if (w_s_drop) begin
            r_s_ovr <= 1'b1;
            if (r_s_drop != 8'hFF) begin
                r_s_drop <= r_s_drop + 8'd1;
            end
        end
    end

    assign sOVERRUN = r_s_ovr;
    assign sDROPCNT = r_s_drop;
`endif

endmodule

// File: tb/tb_sync_handshake_data.sv
// Scoreboard bench: instance 0 auto-ack, instance 1 explicit-ack (DINIT=0x5A).
`timescale 1ns/1ps
module tb_sync_handshake_data;

    logic       sCLK = 1'b0;
    logic       dCLK = 1'b0;
    logic       sRST_N = 1'b0;
    logic       sEN [2];
    logic [7:0] sD_IN [2];
    logic       sRDY [2];
    logic       dACK [2];
    logic       dVALID [2];
    logic [7:0] dD_OUT [2];
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
    logic       sCLR [2];
    logic       sOVERRUN [2];
    logic [7:0] sDROPCNT [2];
`endif

    int s_half = 5;
    int d_half = 15;

    int checks = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int tx0 = 0, rx0 = 0, tx1 = 0, rx1 = 0;

    bit         blk1 = 1'b0;
    bit         have1 = 1'b0;
    bit         pend1 = 1'b0;
    logic [7:0] cur1 = 8'h00;

    sync_handshake_data #(.ACK_MODE(0)) u_dut0 (
        .sCLK(sCLK), .sRST_N(sRST_N), .dCLK(dCLK),
        .sEN(sEN[0]), .sD_IN(sD_IN[0]), .sRDY(sRDY[0]),
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
        .sCLR(sCLR[0]), .sOVERRUN(sOVERRUN[0]), .sDROPCNT(sDROPCNT[0]),
`endif
        .dACK(dACK[0]), .dVALID(dVALID[0]), .dD_OUT(dD_OUT[0])
    );

    sync_handshake_data #(.ACK_MODE(1), .DINIT(8'h5A)) u_dut1 (
        .sCLK(sCLK), .sRST_N(sRST_N), .dCLK(dCLK),
        .sEN(sEN[1]), .sD_IN(sD_IN[1]), .sRDY(sRDY[1]),
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
        .sCLR(sCLR[1]), .sOVERRUN(sOVERRUN[1]), .sDROPCNT(sDROPCNT[1]),
`endif
        .dACK(dACK[1]), .dVALID(dVALID[1]), .dD_OUT(dD_OUT[1])
    );

    initial forever #(s_half) sCLK = ~sCLK;
    initial begin
        #2;
        forever #(d_half) dCLK = ~dCLK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: every accepted word is queued, delivered once, in order
    always @(posedge sCLK) begin
        if (sRST_N && sEN[0] && sRDY[0]) begin
            q0.push_back(sD_IN[0]);
            tx0++;
        end
        if (sRST_N && sEN[1] && sRDY[1]) begin
            q1.push_back(sD_IN[1]);
            tx1++;
        end
    end

    // Auto-ack monitor: each high dCLK cycle is one word
    always @(negedge dCLK) begin
        dACK[0] = 1'($urandom_range(1));
        if (sRST_N && dVALID[0]) begin
            rx0++;
            if (q0.size() == 0) begin
                chk("spurious0", {56'd0, dD_OUT[0]}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("word0", {56'd0, dD_OUT[0]}, {56'd0, q0.pop_front()});
            end
        end
    end

    // Explicit-ack consumer and monitor
    always @(negedge dCLK) begin
        if (!sRST_N) begin
            have1 = 1'b0;
            pend1 = 1'b0;
            dACK[1] = 1'b0;
        end else begin
            if (pend1) begin
                chk("ack1_drop", {63'd0, dVALID[1]}, 64'd0);
                pend1 = 1'b0;
                have1 = 1'b0;
            end else if (dVALID[1]) begin
                if (!have1) begin
                    have1 = 1'b1;
                    rx1++;
                    if (q1.size() == 0) begin
                        cur1 = dD_OUT[1];
                        chk("spurious1", {56'd0, dD_OUT[1]}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        cur1 = q1.pop_front();
                        chk("word1", {56'd0, dD_OUT[1]}, {56'd0, cur1});
                    end
                end else begin
                    chk("hold1", {56'd0, dD_OUT[1]}, {56'd0, cur1});
                end
            end
            if (dVALID[1]) dACK[1] = !blk1 && ($urandom_range(2) == 0);
            else dACK[1] = 1'($urandom_range(1));
            pend1 = dVALID[1] && dACK[1];
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        int n = 0;
        @(negedge sCLK);
        while (!sRDY[k] && n < 400) begin
            @(negedge sCLK);
            n++;
        end
        if (!sRDY[k]) begin
            chk("send_tmo", 64'd0, 64'd1);
        end else begin
            sEN[k] = 1'b1;
            sD_IN[k] = d;
            @(posedge sCLK);
            #1;
            sEN[k] = 1'b0;
            chk("rdy_drop", {63'd0, sRDY[k]}, 64'd0);
        end
    endtask

    // sEN held high; data advances only after each accepted edge
    task automatic stream(input int k, input int n, input logic [7:0] base);
        int i = 0;
        int b = 0;
        logic r;
        sD_IN[k] = base;
        sEN[k] = 1'b1;
        while (i < n && b < 4000) begin
            @(negedge sCLK);
            r = sRDY[k];
            @(posedge sCLK);
            #1;
            b++;
            if (r) begin
                i++;
                sD_IN[k] = base + 8'(i);
            end
        end
        sEN[k] = 1'b0;
        chk("stream_done", 64'(i), 64'(n));
    endtask

    task automatic drain();
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && sRDY[0] && sRDY[1])
               && n < 2000) begin
            @(negedge sCLK);
            n++;
        end
        chk("drain", {63'd0, (q0.size() == 0 && q1.size() == 0
                              && sRDY[0] && sRDY[1])}, 64'd1);
    endtask

    task automatic wait_valid(input int k);
        int n = 0;
        while (!dVALID[k] && n < 40) begin
            @(negedge dCLK);
            n++;
        end
        chk("wait_valid", {63'd0, dVALID[k]}, 64'd1);
    endtask

    task automatic release_rst();
        @(negedge sCLK);
        sRST_N = 1'b1;
        @(posedge sCLK);
        #1;
        chk("rdy_edge1_0", {63'd0, sRDY[0]}, 64'd0);
        chk("rdy_edge1_1", {63'd0, sRDY[1]}, 64'd0);
        @(posedge sCLK);
        #1;
        chk("rdy_edge2_0", {63'd0, sRDY[0]}, 64'd1);
        chk("rdy_edge2_1", {63'd0, sRDY[1]}, 64'd1);
    endtask

`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
    task automatic hold_en(input int k, input int n);
        @(negedge sCLK);
        sEN[k] = 1'b1;
        repeat (n) @(posedge sCLK);
        #1;
        sEN[k] = 1'b0;
    endtask
`endif

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            sEN[k] = 1'b0;
            sD_IN[k] = 8'h00;
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
            sCLR[k] = 1'b0;
`endif
        end
        dACK[0] = 1'b0;
        dACK[1] = 1'b0;

        // Reset state
        #100;
        chk("rst_rdy0", {63'd0, sRDY[0]}, 64'd0);
        chk("rst_rdy1", {63'd0, sRDY[1]}, 64'd0);
        chk("rst_vld0", {63'd0, dVALID[0]}, 64'd0);
        chk("rst_vld1", {63'd0, dVALID[1]}, 64'd0);
        chk("rst_dout0", {56'd0, dD_OUT[0]}, 64'h00);
        chk("rst_dout1", {56'd0, dD_OUT[1]}, 64'h5A);
`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
        chk("rst_ovr", {63'd0, sOVERRUN[1]}, 64'd0);
        chk("rst_cnt", {56'd0, sDROPCNT[1]}, 64'd0);
`endif
        release_rst();

        // Auto-ack latency and pulse width
        send(0, 8'hA5);
        n = 0;
        while (!dVALID[0] && n < 10) begin
            @(posedge dCLK);
            #1;
            n++;
        end
        chk("lat_a5", {63'd0, (n >= 2 && n <= 3)}, 64'd1);
        chk("dout_a5", {56'd0, dD_OUT[0]}, 64'hA5);
        @(posedge dCLK);
        #1;
        chk("pulse_a5", {63'd0, dVALID[0]}, 64'd0);
        drain();

        // Explicit ack held off for 10 dCLK
        blk1 = 1'b1;
        send(1, 8'h3C);
        wait_valid(1);
        repeat (10) begin
            @(negedge dCLK);
            chk("hold_v1", {63'd0, dVALID[1]}, 64'd1);
            chk("hold_d1", {56'd0, dD_OUT[1]}, 64'h3C);
        end
        blk1 = 1'b0;
        drain();

        // Back-to-back streams, slow sCLK / fast dCLK then swapped
        s_half = 15;
        d_half = 4;
        fork
            stream(0, 16, 8'h01);
            stream(1, 16, 8'h01);
        join
        drain();
        s_half = 4;
        d_half = 15;
        fork
            stream(0, 16, 8'h01);
            stream(1, 16, 8'h01);
        join
        drain();
        s_half = 5;
        d_half = 15;

        // Random words with random gaps
        fork
            for (int i = 0; i < 30; i++) begin
                send(0, 8'($urandom));
                repeat ($urandom_range(3)) @(negedge sCLK);
            end
            for (int i = 0; i < 30; i++) begin
                send(1, 8'($urandom));
                repeat ($urandom_range(3)) @(negedge sCLK);
            end
        join
        drain();
        chk("count0", 64'(rx0), 64'(tx0));
        chk("count1", 64'(rx1), 64'(tx1));

        // Park a word on instance 1
        blk1 = 1'b1;
        send(1, 8'h77);
        wait_valid(1);

`ifdef SYNC_HANDSHAKE_DATA_OVERRUN_EN
        hold_en(1, 5);
        chk("rdy_blocked", {63'd0, sRDY[1]}, 64'd0);
        chk("ovr_5", {63'd0, sOVERRUN[1]}, 64'd1);
        chk("cnt_5", {56'd0, sDROPCNT[1]}, 64'd5);
        hold_en(1, 295);
        chk("cnt_sat", {56'd0, sDROPCNT[1]}, 64'd255);
        @(negedge sCLK);
        sCLR[1] = 1'b1;
        sEN[1] = 1'b1;
        @(posedge sCLK);
        #1;
        sCLR[1] = 1'b0;
        sEN[1] = 1'b0;
        chk("clr_ovr", {63'd0, sOVERRUN[1]}, 64'd0);
        chk("clr_cnt", {56'd0, sDROPCNT[1]}, 64'd0);
`endif

        // Reset while dVALID is high drops the word
        @(negedge sCLK);
        chk("pre_rst_vld", {63'd0, dVALID[1]}, 64'd1);
        sRST_N = 1'b0;
        #1;
        chk("mid_rst_vld", {63'd0, dVALID[1]}, 64'd0);
        chk("mid_rst_dout", {56'd0, dD_OUT[1]}, 64'h5A);
        chk("mid_rst_rdy", {63'd0, sRDY[1]}, 64'd0);
        tx0 -= q0.size();
        tx1 -= q1.size();
        q0.delete();
        q1.delete();
        repeat (3) @(negedge dCLK);
        blk1 = 1'b0;
        release_rst();
        repeat (20) begin
            @(negedge dCLK);
            chk("post_rst_vld0", {63'd0, dVALID[0]}, 64'd0);
            chk("post_rst_vld1", {63'd0, dVALID[1]}, 64'd0);
        end

        // One more word after reset proves recovery
        send(1, 8'hC3);
        drain();
        chk("final0", 64'(rx0), 64'(tx0));
        chk("final1", 64'(rx1), 64'(tx1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
